vx_fetch_scheduler: RTL and testbench
=====================================

VX_FETCH_SCHEDULER -- requirements
Module: VX_fetch_scheduler

Interface
REQ-001 SHALL have parameter WARP_CNT, default `NUM_WARPS, number of warps scheduled.
REQ-002 SHALL have parameter THREAD_CNT, default `NUM_THREADS, tmask width.
REQ-003 SHALL have parameter ISSUE_CNT, default `MIN(WARP_CNT,4), width of the flush vector.
REQ-004 SHALL have parameter MAX_INFLIGHT, default 2*(WARP_CNT/ISSUE_CNT), per-warp outstanding fetch limit.
REQ-005 SHALL have port clk, input, 1, the single clock; reset is asynchronous and active-high.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports start_valid/start_wid/start_pc, input, 1/`NW_WIDTH/`XLEN, activate an idle warp at a PC.
REQ-008 SHALL have ports stop_valid/stop_wid, input, 1/`NW_WIDTH, deactivate a warp.
REQ-009 SHALL have port stall_mask, input, WARP_CNT, per-warp fetch hold from decode/join.
REQ-010 SHALL have ports redirect_valid/redirect_wid/redirect_pc, input, 1/`NW_WIDTH/`XLEN, mispredict correction.
REQ-011 SHALL have ports rsp_fire/rsp_wid, input, 1/`NW_WIDTH, fetch response accepted downstream.
REQ-012 SHALL have ports sched_valid/sched_ready, output/input, 1/1, request handshake to fetch.
REQ-013 SHALL have ports sched_wid/sched_pc/sched_tmask/sched_uuid, output, `NW_WIDTH/`XLEN/THREAD_CNT/`UUID_WIDTH, request payload.
REQ-014 SHALL have port mispredict_flush, output, ISSUE_CNT, drives the fetch unit's flush input.
REQ-015 SHALL have port active_warps, output, WARP_CNT, current active mask.

Function
REQ-016 SHALL keep per warp: active bit, fetch_pc (next to request), expect_pc (PC of oldest unreturned fetch), inflight counter (0..MAX_INFLIGHT).
REQ-017 SHALL treat warp w eligible when active, !stall_mask[w], inflight<MAX_INFLIGHT, no flush this cycle.
REQ-018 SHALL select one eligible warp per cycle by round-robin, priority rotating past the last winner.
REQ-019 SHALL load the winner into a registered output slot when the slot is empty or firing (sched_valid&&sched_ready); latency 1 cycle.
REQ-020 SHALL hold sched_* payload stable while sched_valid&&!sched_ready.
REQ-021 On selection: fetch_pc[w]+=4, inflight[w]+=1, sched_tmask = all ones, sched_uuid = uuid counter, counter +1 (wraps mod 2^`UUID_WIDTH).
REQ-022 On rsp_fire: expect_pc[rsp_wid]+=4, inflight[rsp_wid]-=1; simultaneous selection and response for the same warp leaves inflight unchanged.
REQ-023 On redirect_valid for an active warp: assert mispredict_flush[wid mod ISSUE_CNT] for exactly that cycle, others 0.
REQ-024 In the redirect cycle: all inflight cleared; every other warp fetch_pc<=expect_pc; redirected warp fetch_pc and expect_pc<=redirect_pc; output slot invalidated next cycle; no selection.
REQ-025 SHALL ignore rsp_fire in a redirect cycle (response is squashed by fetch).
REQ-026 start_valid on an idle warp: active=1, fetch_pc=expect_pc=start_pc, inflight=0; ignored for an active warp.
REQ-027 stop_valid: active=0 next cycle; stop wins over redirect and start on the same warp same cycle; a held slot of that warp still completes.
REQ-028 redirect_valid on an inactive warp SHALL be ignored (no flush).
REQ-029 SHALL never select a warp with inflight==MAX_INFLIGHT; counter SHALL never underflow (assert).

Reset
REQ-030 During reset all warps inactive, PCs 0, inflight 0, RR pointer 0, uuid 0, sched_valid=0, mispredict_flush=0, active_warps=0.
REQ-031 Reset SHALL take effect asynchronously mid-operation and discard the held slot.

Structure
REQ-032 `NW_WIDTH, `UUID_WIDTH, `XLEN SHALL come from the shared VX_gpu_pkg/VX_define.vh; no new typedefs are required.
REQ-033 Arbitration SHALL use one VX_rr_arbiter instance (NUM_REQS=WARP_CNT); all other state is local.

Verification
REQ-034 Start w0@0x80000000, sched_ready=1, no rsp -> PCs 0x80000000,0x80000004 issued, then sched_valid=0 (MAX_INFLIGHT=2).
REQ-035 Start w0,w1 both @0x1000, ready=1, rsp each fetch -> wid alternates 0,1,0,1; uuid 0,1,2,3.
REQ-036 w0 two in flight (0x1000,0x1004), w1 one (0x2000); redirect w0->0x3000 -> flush bit0 one cycle, next w1 PC 0x2000, w0 PC 0x3000.
REQ-037 sched_ready=0 three cycles with slot valid -> wid/pc/uuid unchanged; stall_mask[0]=1 -> w0 never selected.
REQ-038 Same cycle stop w1 and redirect w1 -> no flush, w1 inactive; redirect w2 inactive -> no flush.
REQ-039 Assert reset mid-stream with slot valid -> sched_valid=0 immediately, active_warps=0.

Source files
------------

// File: rtl/vx_fetch_scheduler_pkg.sv
// vx_fetch_scheduler_pkg: shared GPU widths and helpers for the fetch scheduler
package vx_fetch_scheduler_pkg;
  localparam int NUM_WARPS   = 4;
  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int UUID_WIDTH  = 8;
  localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/vx_fetch_scheduler_arb.sv
// vx_fetch_scheduler_arb: round-robin arbiter whose priority rotates past the last winner
module vx_fetch_scheduler_arb #(
  parameter int NUM_REQS = 4,
  parameter int IW       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests_i,
  input  logic                enable_i,
  output logic                grant_valid_o,
  output logic [IW-1:0]       grant_idx_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  // scan from the pointer; descending loop lets the closest request win
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (requests_i[(int'(ptr_q) + i) % NUM_REQS]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = IW'((int'(ptr_q) + i) % NUM_REQS);
      end
    end
  end
  // advance priority to the slot just past an accepted winner
  always_comb begin
    ptr_d = (enable_i && grant_valid_o)
          ? ((int'(grant_idx_o) == NUM_REQS - 1) ? '0 : grant_idx_o + IW'(1))
          : ptr_q;
  end
  // pointer register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/vx_fetch_scheduler.sv
// vx_fetch_scheduler: per-warp PC tracking and round-robin fetch request issue
module vx_fetch_scheduler
  import vx_fetch_scheduler_pkg::*;
#(
  parameter int WARP_CNT     = NUM_WARPS,
  parameter int THREAD_CNT   = NUM_THREADS,
  parameter int ISSUE_CNT    = min_int(WARP_CNT, 4),
  parameter int MAX_INFLIGHT = 2 * (WARP_CNT / ISSUE_CNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_valid_i,
  input  logic [NW_WIDTH-1:0]   start_wid_i,
  input  logic [XLEN-1:0]       start_pc_i,
  input  logic                  stop_valid_i,
  input  logic [NW_WIDTH-1:0]   stop_wid_i,
  input  logic [WARP_CNT-1:0]   stall_mask_i,
  input  logic                  redirect_valid_i,
  input  logic [NW_WIDTH-1:0]   redirect_wid_i,
  input  logic [XLEN-1:0]       redirect_pc_i,
  input  logic                  rsp_fire_i,
  input  logic [NW_WIDTH-1:0]   rsp_wid_i,
  output logic                  sched_valid_o,
  input  logic                  sched_ready_i,
  output logic [NW_WIDTH-1:0]   sched_wid_o,
  output logic [XLEN-1:0]       sched_pc_o,
  output logic [THREAD_CNT-1:0] sched_tmask_o,
  output logic [UUID_WIDTH-1:0] sched_uuid_o,
  output logic [ISSUE_CNT-1:0]  mispredict_flush_o,
  output logic [WARP_CNT-1:0]   active_warps_o
);
  localparam int IFW = $clog2(MAX_INFLIGHT + 1);
  logic [WARP_CNT-1:0]   active_q, active_d, eligible, sel_vec, rsp_vec;
  logic [XLEN-1:0]       fetch_pc_q [WARP_CNT];
  logic [XLEN-1:0]       fetch_pc_d [WARP_CNT];
  logic [XLEN-1:0]       expect_pc_q [WARP_CNT];
  logic [XLEN-1:0]       expect_pc_d [WARP_CNT];
  logic [IFW-1:0]        inflight_q [WARP_CNT];
  logic [IFW-1:0]        inflight_d [WARP_CNT];
  logic                  slot_v_q, slot_v_d;
  logic [NW_WIDTH-1:0]   slot_wid_q, slot_wid_d, grant_idx;
  logic [XLEN-1:0]       slot_pc_q, slot_pc_d;
  logic [UUID_WIDTH-1:0] slot_uuid_q, slot_uuid_d, uuid_q, uuid_d;
  logic                  redir_ok, load, grant_valid, sel;
  // a redirect counts only for an active warp that is not being stopped in the same cycle
  assign redir_ok = redirect_valid_i && active_q[redirect_wid_i]
                 && !(stop_valid_i && stop_wid_i == redirect_wid_i);
  assign load     = !slot_v_q || sched_ready_i;
  assign sel      = load && grant_valid && !redir_ok;
  // eligibility plus per-warp select/response strobes
  always_comb begin
    eligible = '0;
    sel_vec  = '0;
    rsp_vec  = '0;
    for (int w = 0; w < WARP_CNT; w++) begin
      eligible[w] = active_q[w] && !stall_mask_i[w] && (inflight_q[w] < IFW'(MAX_INFLIGHT)) && !redir_ok;
      sel_vec[w]  = sel && grant_idx == NW_WIDTH'(w);
      rsp_vec[w]  = rsp_fire_i && rsp_wid_i == NW_WIDTH'(w) && !redir_ok;
    end
  end
  vx_fetch_scheduler_arb #(.NUM_REQS(WARP_CNT), .IW(NW_WIDTH)) u_arb (
    .clk           (clk),
    .reset         (reset),
    .requests_i    (eligible),
    .enable_i      (sel),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );
  // flush pulse targets the issue slice that owns the redirected warp
  always_comb begin
    mispredict_flush_o = '0;
    if (redir_ok) mispredict_flush_o[int'(redirect_wid_i) % ISSUE_CNT] = 1'b1;
  end
  // per-warp state: redirect rewinds, start seeds, stop overrides everything
  always_comb begin
    active_d    = active_q;
    fetch_pc_d  = fetch_pc_q;
    expect_pc_d = expect_pc_q;
    inflight_d  = inflight_q;
    for (int w = 0; w < WARP_CNT; w++) begin
      if (redir_ok) begin
        inflight_d[w] = '0;
        fetch_pc_d[w] = (redirect_wid_i == NW_WIDTH'(w)) ? redirect_pc_i : expect_pc_q[w];
        if (redirect_wid_i == NW_WIDTH'(w)) expect_pc_d[w] = redirect_pc_i;
      end else begin
        if (sel_vec[w]) fetch_pc_d[w] = fetch_pc_q[w] + XLEN'(4);
        if (rsp_vec[w]) expect_pc_d[w] = expect_pc_q[w] + XLEN'(4);
        inflight_d[w] = inflight_q[w] + IFW'(sel_vec[w]) - IFW'(rsp_vec[w]);
      end
      if (start_valid_i && start_wid_i == NW_WIDTH'(w) && !active_q[w]) begin
        active_d[w]    = 1'b1;
        fetch_pc_d[w]  = start_pc_i;
        expect_pc_d[w] = start_pc_i;
        inflight_d[w]  = '0;
      end
      if (stop_valid_i && stop_wid_i == NW_WIDTH'(w)) active_d[w] = 1'b0;
    end
  end
  // output slot: reload when empty or firing, dropped by a redirect
  always_comb begin
    slot_v_d    = slot_v_q;
    slot_wid_d  = slot_wid_q;
    slot_pc_d   = slot_pc_q;
    slot_uuid_d = slot_uuid_q;
    uuid_d      = uuid_q;
    if (redir_ok) slot_v_d = 1'b0;
    else if (load) begin
      slot_v_d = grant_valid;
      if (grant_valid) begin
        slot_wid_d  = grant_idx;
        slot_pc_d   = fetch_pc_q[grant_idx];
        slot_uuid_d = uuid_q;
        uuid_d      = uuid_q + UUID_WIDTH'(1);
      end
    end
  end
  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q    <= '0;
      slot_v_q    <= 1'b0;
      slot_wid_q  <= '0;
      slot_pc_q   <= '0;
      slot_uuid_q <= '0;
      uuid_q      <= '0;
      for (int w = 0; w < WARP_CNT; w++) begin
        fetch_pc_q[w]  <= '0;
        expect_pc_q[w] <= '0;
        inflight_q[w]  <= '0;
      end
    end else begin
      active_q    <= active_d;
      slot_v_q    <= slot_v_d;
      slot_wid_q  <= slot_wid_d;
      slot_pc_q   <= slot_pc_d;
      slot_uuid_q <= slot_uuid_d;
      uuid_q      <= uuid_d;
      fetch_pc_q  <= fetch_pc_d;
      expect_pc_q <= expect_pc_d;
      inflight_q  <= inflight_d;
    end
  end
  assign sched_valid_o  = slot_v_q;
  assign sched_wid_o    = slot_wid_q;
  assign sched_pc_o     = slot_pc_q;
  assign sched_uuid_o   = slot_uuid_q;
  assign sched_tmask_o  = '1;
  assign active_warps_o = active_q;
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    (rsp_fire_i && !redir_ok) |-> inflight_q[rsp_wid_i] != '0);
endmodule

// File: tb/tb_vx_fetch_scheduler.sv
// tb_vx_fetch_scheduler: directed checks of issue order, redirect, hold, stop and reset
module tb_vx_fetch_scheduler;
  import vx_fetch_scheduler_pkg::*;
  logic                   clk = 1'b0, reset = 1'b1;
  logic                   start_valid = 1'b0, stop_valid = 1'b0, redirect_valid = 1'b0;
  logic                   rsp_fire = 1'b0, sched_ready = 1'b0;
  logic [NW_WIDTH-1:0]    start_wid = '0, stop_wid = '0, redirect_wid = '0, rsp_wid = '0;
  logic [XLEN-1:0]        start_pc = '0, redirect_pc = '0;
  logic [NUM_WARPS-1:0]   stall_mask = '0;
  logic                   sched_valid;
  logic [NW_WIDTH-1:0]    sched_wid;
  logic [XLEN-1:0]        sched_pc;
  logic [NUM_THREADS-1:0] sched_tmask;
  logic [UUID_WIDTH-1:0]  sched_uuid;
  logic [3:0]             flush;
  logic [NUM_WARPS-1:0]   active;
  int checks = 0, failures = 0;

  vx_fetch_scheduler dut (
    .clk (clk), .reset (reset),
    .start_valid_i (start_valid), .start_wid_i (start_wid), .start_pc_i (start_pc),
    .stop_valid_i (stop_valid), .stop_wid_i (stop_wid), .stall_mask_i (stall_mask),
    .redirect_valid_i (redirect_valid), .redirect_wid_i (redirect_wid), .redirect_pc_i (redirect_pc),
    .rsp_fire_i (rsp_fire), .rsp_wid_i (rsp_wid),
    .sched_valid_o (sched_valid), .sched_ready_i (sched_ready), .sched_wid_o (sched_wid),
    .sched_pc_o (sched_pc), .sched_tmask_o (sched_tmask), .sched_uuid_o (sched_uuid),
    .mispredict_flush_o (flush), .active_warps_o (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    {start_valid, stop_valid, redirect_valid, rsp_fire, sched_ready} = '0;
    stall_mask = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic start(input int w, input logic [XLEN-1:0] pc);
    start_valid = 1'b1;
    start_wid   = NW_WIDTH'(w);
    start_pc    = pc;
  endtask

  task automatic slot(input string tag, input int w, input logic [XLEN-1:0] pc, input int u);
    check({tag, "_valid"}, sched_valid, 1);
    check({tag, "_wid"}, sched_wid, w);
    check({tag, "_pc"}, sched_pc, pc);
    check({tag, "_uuid"}, sched_uuid, u);
  endtask

  initial begin
    // reset state
    do_reset();
    check("rst_valid", sched_valid, 0);
    check("rst_active", active, 0);
    check("rst_flush", flush, 0);
    check("rst_uuid", sched_uuid, 0);
    // single warp hits the inflight limit; restart of an active warp is ignored
    sched_ready = 1'b1;
    start(0, 32'h8000_0000);
    tick();
    check("t1_active", active, 4'b0001);
    start(0, 32'h0000_7777);
    tick();
    start_valid = 1'b0;
    slot("t1_a", 0, 32'h8000_0000, 0);
    check("t1_tmask", sched_tmask, 4'hF);
    tick();
    slot("t1_b", 0, 32'h8000_0004, 1);
    tick();
    check("t1_limit", sched_valid, 0);
    tick();
    check("t1_limit2", sched_valid, 0);
    // two warps alternate with a response per fetch
    do_reset();
    sched_ready = 1'b1;
    start(0, 32'h1000);
    tick();
    start(1, 32'h1000);
    for (int k = 0; k < 4; k++) begin
      tick();
      start_valid = 1'b0;
      slot($sformatf("t2_%0d", k), k % 2, 32'h1000 + 4 * (k / 2), k);
      rsp_fire = 1'b1;
      rsp_wid  = NW_WIDTH'(k % 2);
    end
    rsp_fire = 1'b0;
    // redirect with mixed inflight counts
    do_reset();
    sched_ready = 1'b1;
    start(0, 32'h1000);
    tick();
    start(1, 32'h2000);
    stall_mask = 4'b0010;
    tick();
    start_valid = 1'b0;
    slot("t3_a", 0, 32'h1000, 0);
    tick();
    slot("t3_b", 0, 32'h1004, 1);
    stall_mask = 4'b0000;
    tick();
    slot("t3_c", 1, 32'h2000, 2);
    stall_mask     = 4'b0010;
    redirect_valid = 1'b1;
    redirect_wid   = 0;
    redirect_pc    = 32'h3000;
    #1;
    check("t3_flush", flush, 4'b0001);
    tick();
    redirect_valid = 1'b0;
    stall_mask     = 4'b0001;
    #1;
    check("t3_squash", sched_valid, 0);
    check("t3_flush_off", flush, 0);
    tick();
    slot("t3_d", 1, 32'h2000, 3);
    stall_mask = 4'b0000;
    tick();
    slot("t3_e", 0, 32'h3000, 4);
    // backpressure hold, then a stalled warp is never picked
    do_reset();
    start(0, 32'h0500);
    tick();
    start_valid = 1'b0;
    tick();
    slot("t4_load", 0, 32'h0500, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      slot($sformatf("t4_hold%0d", k), 0, 32'h0500, 0);
    end
    sched_ready = 1'b1;
    stall_mask  = 4'b0001;
    start(1, 32'h0600);
    tick();
    start_valid = 1'b0;
    check("t4_empty", sched_valid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      slot($sformatf("t4_w1_%0d", k), 1, 32'h0600 + 4 * k, 1 + k);
      rsp_fire = 1'b1;
      rsp_wid  = 1;
    end
    rsp_fire = 1'b0;
    // stop beats redirect on the same warp; redirect of an idle warp is ignored
    do_reset();
    sched_ready = 1'b1;
    start(1, 32'h0100);
    tick();
    start_valid    = 1'b0;
    check("t5_active", active, 4'b0010);
    stop_valid     = 1'b1;
    stop_wid       = 1;
    redirect_valid = 1'b1;
    redirect_wid   = 1;
    redirect_pc    = 32'h0900;
    #1;
    check("t5_stop_flush", flush, 0);
    tick();
    stop_valid = 1'b0;
    check("t5_inactive", active, 0);
    redirect_wid = 2;
    #1;
    check("t5_idle_flush", flush, 0);
    tick();
    redirect_valid = 1'b0;
    // asynchronous reset drops a held slot
    do_reset();
    start(0, 32'h0040);
    tick();
    start_valid = 1'b0;
    tick();
    check("t6_held", sched_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    check("t6_valid", sched_valid, 0);
    check("t6_active", active, 0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_after", sched_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
